color_matrix_pipe: RTL and testbench

COLOR_MATRIX_PIPE -- requirements
Module: color_matrix_pipe

---
 rtl/color_matrix_pipe.sv | 154 +++++++++++++++
 tb/tb_color_matrix_pipe.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/color_matrix_pipe.sv
// 3x3 colour matrix, 3-stage multiply/sum/round-saturate pipeline, double-buffered coefficients.
// Optional per-channel offsets at coef_addr 9..11 when CSC_OFFSET_EN is defined.
module color_matrix_pipe #(
    parameter int IN_W   = 8,
    parameter int COEF_W = 16,
    parameter int FRAC_W = 12,
    parameter int OUT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic [IN_W-1:0]   in_c0,
    input  logic [IN_W-1:0]   in_c1,
    input  logic [IN_W-1:0]   in_c2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic [OUT_W-1:0]  out_c0,
    output logic [OUT_W-1:0]  out_c1,
    output logic [OUT_W-1:0]  out_c2,
    output logic [2:0]        out_sat,
    input  logic              coef_we,
    input  logic [3:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_wdata
);

`ifdef CSC_OFFSET_EN
    localparam int NCOEF = 12;
`else
    localparam int NCOEF = 9;
`endif
    localparam int P_W = IN_W + COEF_W + 1;
    localparam int S_W = IN_W + COEF_W + 3;
    localparam logic [COEF_W-1:0] ONE = COEF_W'(1) << FRAC_W;
    localparam logic signed [S_W-1:0] RND = S_W'(1) << (FRAC_W - 1);
    localparam logic [OUT_W-1:0] MAXV = '1;

    logic                     en;
    logic                     sof_acc;
    logic [IN_W-1:0]          in_c [3];
    logic signed [COEF_W-1:0] shadow [NCOEF];
    logic signed [COEF_W-1:0] active [NCOEF];
    logic signed [COEF_W-1:0] cuse [NCOEF];
    logic signed [P_W-1:0]    prod [9];
    logic signed [P_W-1:0]    s1_prod [9];
    logic                     s1_valid;
    logic                     s1_sof;
    logic signed [S_W-1:0]    off_x [3];
    logic signed [S_W-1:0]    sum [3];
    logic signed [S_W-1:0]    s2_sum [3];
    logic                     s2_valid;
    logic                     s2_sof;
    logic [OUT_W-1:0]         res [3];
    logic [2:0]               sat;
`ifdef CSC_OFFSET_EN
    logic signed [COEF_W-1:0] s1_off [3];
`endif

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign sof_acc  = en && in_valid && in_sof;
    assign in_c[0]  = in_c0;
    assign in_c[1]  = in_c1;
    assign in_c[2]  = in_c2;

    // A frame-start beat sees the shadow bank in the same cycle it is promoted.
    for (genvar i = 0; i < NCOEF; i++) begin : g_cuse
        assign cuse[i] = sof_acc ? shadow[i] : active[i];
    end

    for (genvar k = 0; k < 3; k++) begin : g_row
        for (genvar j = 0; j < 3; j++) begin : g_col
            assign prod[3*k+j] = P_W'($signed({1'b0, in_c[j]}))
                               * P_W'(cuse[3*k+j]);
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_ch
        logic signed [S_W-1:0] rnd;
        logic signed [S_W-1:0] shf;
        logic                  neg;
        logic                  ovf;
`ifdef CSC_OFFSET_EN
        assign off_x[k] = S_W'(s1_off[k]);
`else
        assign off_x[k] = '0;
`endif
        assign sum[k] = S_W'(s1_prod[3*k]) + S_W'(s1_prod[3*k+1])
                      + S_W'(s1_prod[3*k+2]) + off_x[k];
        assign rnd    = s2_sum[k] + RND;
        assign shf    = rnd >>> FRAC_W;
        assign neg    = shf[S_W-1];
        assign ovf    = !neg && (|shf[S_W-2:OUT_W]);
        assign res[k] = neg ? '0 : (ovf ? MAXV : shf[OUT_W-1:0]);
        assign sat[k] = neg || ovf;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCOEF; i++) begin
                shadow[i] <= (i % 4 == 0 && i < 9) ? ONE : '0;
                active[i] <= (i % 4 == 0 && i < 9) ? ONE : '0;
            end
        end else begin
            if (sof_acc) begin
                for (int i = 0; i < NCOEF; i++) active[i] <= shadow[i];
            end
            if (coef_we && coef_addr < 4'(NCOEF)) begin
                shadow[coef_addr] <= coef_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sof    <= 1'b0;
            s2_valid  <= 1'b0;
            s2_sof    <= 1'b0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_sat   <= '0;
            out_c0    <= '0;
            out_c1    <= '0;
            out_c2    <= '0;
            for (int i = 0; i < 9; i++) s1_prod[i] <= '0;
            for (int i = 0; i < 3; i++) s2_sum[i] <= '0;
`ifdef CSC_OFFSET_EN
            for (int i = 0; i < 3; i++) s1_off[i] <= '0;
`endif
        end else if (en) begin
            s1_valid  <= in_valid;
            s1_sof    <= in_valid && in_sof;
            for (int i = 0; i < 9; i++) s1_prod[i] <= prod[i];
`ifdef CSC_OFFSET_EN
            s1_off[0] <= cuse[9];
            s1_off[1] <= cuse[10];
            s1_off[2] <= cuse[11];
`endif
            s2_valid  <= s1_valid;
            s2_sof    <= s1_sof;
            for (int i = 0; i < 3; i++) s2_sum[i] <= sum[i];
            out_valid <= s2_valid;
            out_sof   <= s2_sof;
            out_sat   <= sat;
            out_c0    <= res[0];
            out_c1    <= res[1];
            out_c2    <= res[2];
        end
    end

endmodule

// File: tb/tb_color_matrix_pipe.sv
// Randomized and directed bench for color_matrix_pipe against a plain-arithmetic model.
// Honours CSC_OFFSET_EN the same way as the design.
module tb_color_matrix_pipe;

    localparam int IN_W   = 8;
    localparam int COEF_W = 16;
    localparam int FRAC_W = 12;
    localparam int OUT_W  = 8;
`ifdef CSC_OFFSET_EN
    localparam int NC = 12;
`else
    localparam int NC = 9;
`endif
    localparam longint HALF = longint'(1) << (FRAC_W - 1);
    localparam longint MAXO = (longint'(1) << OUT_W) - 1;
    localparam int     UNIT = 1 << FRAC_W;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic              in_sof;
    logic [IN_W-1:0]   in_c0, in_c1, in_c2;
    logic              out_valid;
    logic              out_ready;
    logic              out_sof;
    logic [OUT_W-1:0]  out_c0, out_c1, out_c2;
    logic [2:0]        out_sat;
    logic              coef_we;
    logic [3:0]        coef_addr;
    logic [COEF_W-1:0] coef_wdata;

    int n_chk  = 0;
    int n_pass = 0;
    int sh_m [12];
    int act_m [12];
    logic [31:0] exp_q [$];

    color_matrix_pipe #(
        .IN_W(IN_W), .COEF_W(COEF_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .in_c0(in_c0), .in_c1(in_c1), .in_c2(in_c2),
        .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
        .out_c0(out_c0), .out_c1(out_c1), .out_c2(out_c2),
        .out_sat(out_sat),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] model(int a, int b, int c, bit s);
        logic [OUT_W-1:0] o [3];
        logic [2:0] st;
        longint acc, r;
        for (int k = 0; k < 3; k++) begin
            acc = longint'(act_m[3*k]) * a + longint'(act_m[3*k+1]) * b
                + longint'(act_m[3*k+2]) * c + longint'(act_m[9+k]);
            r = (acc + HALF) >>> FRAC_W;
            st[k] = (r < 0) || (r > MAXO);
            if (r < 0) o[k] = '0;
            else if (r > MAXO) o[k] = OUT_W'(MAXO);
            else o[k] = OUT_W'(r);
        end
        return {4'b0, s, st, o[2], o[1], o[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 12; i++) begin
            sh_m[i]  = (i == 0 || i == 4 || i == 8) ? UNIT : 0;
            act_m[i] = sh_m[i];
        end
        exp_q.delete();
    endtask

    task automatic step(input bit v, input bit s, input int a, input int b,
                        input int c, input bit rdy, input bit we,
                        input int addr, input int wd);
        @(negedge clk);
        in_valid   = v;
        in_sof     = s;
        in_c0      = IN_W'(a);
        in_c1      = IN_W'(b);
        in_c2      = IN_W'(c);
        out_ready  = rdy;
        coef_we    = we;
        coef_addr  = 4'(addr);
        coef_wdata = COEF_W'(wd);
        #1;
        if (out_valid) begin
            if (exp_q.size() == 0) check("spurious_beat", 32'd1, 32'd0);
            else begin
                check("beat", {4'b0, out_sof, out_sat, out_c2, out_c1, out_c0},
                      exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
        if (in_valid && in_ready) begin
            if (in_sof) act_m = sh_m;
            exp_q.push_back(model(int'(in_c0), int'(in_c1), int'(in_c2), in_sof));
        end
        if (coef_we && int'(coef_addr) < NC)
            sh_m[coef_addr] = int'($signed(coef_wdata));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic wr(input int addr, input int wd);
        step(0, 0, 0, 0, 0, 1, 1, addr, wd);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1);
        check("drain_left", exp_q.size(), 0);
        idle(3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        coef_we  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_outputs", {out_sof, out_sat, out_c2, out_c1, out_c0}, 0);
        check("rst_in_ready_after", in_ready, 1);
        model_reset();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 0; in_sof = 0; out_ready = 1;
        in_c0 = 0; in_c1 = 0; in_c2 = 0;
        coef_we = 0; coef_addr = 0; coef_wdata = 0;
        model_reset();
        do_reset();

        // identity pass-through and 3-cycle latency
        step(1, 1, 10, 20, 30, 1, 0, 0, 0);
        idle(2);
        check("latency_early", out_valid, 0);
        idle(1);
        check("latency_3", out_valid, 1);
        check("pass_through", {out_sat, out_c2, out_c1, out_c0},
              {3'b0, 8'd30, 8'd20, 8'd10});
        drain();

        // stall for 5 cycles mid-stream
        for (int i = 0; i < 13; i++) begin
            step(1, i == 0, 10*i+1, 10*i+2, 10*i+3, !(i >= 4 && i < 9), 0, 0, 0);
            if (i >= 4 && i < 9) check("stall_in_ready", in_ready, 0);
        end
        drain();

        // BT.601 luma row
        wr(0, 1225); wr(1, 2404); wr(2, 467);
        step(1, 1, 255, 255, 255, 1, 0, 0, 0);
        drain();

        // negative clamp on row 1, positive clamp on row 0
        wr(3, -2048); wr(4, 0); wr(5, 0);
        step(1, 1, 100, 0, 0, 1, 0, 0, 0);
        drain();
        wr(0, 8192);
        step(1, 1, 200, 0, 0, 1, 0, 0, 0);
        drain();

        // mid-frame write only takes effect at next sof
        wr(0, 0);
        step(1, 0, 50, 0, 0, 1, 0, 0, 0);
        step(1, 0, 60, 0, 0, 1, 0, 0, 0);
        step(1, 1, 50, 0, 0, 1, 0, 0, 0);
        drain();

        // write coincident with sof lands in shadow only
        step(1, 1, 40, 0, 0, 1, 1, 0, 4096);
        step(1, 0, 40, 0, 0, 1, 0, 0, 0);
        step(1, 1, 40, 0, 0, 1, 0, 0, 0);
        drain();

        // out-of-range addresses
        do_reset();
        wr(13, 1234); wr(15, -1); wr(9, 20000);
        step(1, 1, 77, 88, 99, 1, 0, 0, 0);
        drain();

`ifdef CSC_OFFSET_EN
        do_reset();
        wr(9, 7 << FRAC_W); wr(10, -(3 << FRAC_W));
        step(1, 1, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 250, 2, 9, 1, 0, 0, 0);
        drain();
`endif

        // randomized traffic, writes and back-pressure
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 255), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 15),
                 $urandom_range(0, 12000) - 6000);
        end
        drain();

        // reset mid-stream discards in-flight beats and restores identity
        step(1, 1, 5, 6, 7, 1, 0, 0, 0);
        step(1, 0, 8, 9, 10, 1, 0, 0, 0);
        do_reset();
        idle(4);
        step(1, 1, 123, 45, 67, 1, 0, 0, 0);
        idle(3);
        check("post_reset_identity", {out_sof, out_c2, out_c1, out_c0},
              {1'b1, 8'd67, 8'd45, 8'd123});
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
